mult_div_unit: RTL and testbench

Sequential signed multiply/divide unit on the responder side of the control FSM's mult/div start handshake. Control pulses a start with operands A and B. The unit iterates for 32 cycles, writes HI/LO, and returns a one-cycle `done` that control waits on before issuing MFHI/MFLO. It also raises the `div0` exception flag that control consumes for the divide-by-zero trap.

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mult_div_unit_if.sv | 26 ++
 rtl/mdu_div_core.sv | 55 +++++
 rtl/mult_div_unit.sv | 135 +++++++++++++
 tb/tb_mult_div_unit.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared types and widths for the sequential multiply/divide unit.
// Holds the FSM state encoding and the magnitude helper used by the divider.
package mdu_pkg;

   localparam int MDU_W     = 32;
   localparam int MDU_ITER  = 32;
   localparam int MDU_CNT_W = 6;

   typedef enum logic [1:0] {
      IDLE,
      MULT,
      DIV,
      FIN
   } mdu_state_e;

   function automatic logic [MDU_W-1:0] mdu_abs(input logic [MDU_W-1:0] v);
      return v[MDU_W-1] ? -v : v;
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Start handshake, operands and results between control (master) and the mult/div unit (slave).
// Starts are single-cycle pulses; done/div0 are single-cycle completion pulses.
interface mult_div_unit_if;
   import mdu_pkg::*;

   logic             mult_start;
   logic             div_start;
   logic [MDU_W-1:0] a;
   logic [MDU_W-1:0] b;
   logic             busy;
   logic             done;
   logic             div0;
   logic [MDU_W-1:0] hi;
   logic [MDU_W-1:0] lo;

   modport master (
      output mult_start, div_start, a, b,
      input  busy, done, div0, hi, lo
   );

   modport slave (
      input  mult_start, div_start, a, b,
      output busy, done, div0, hi, lo
   );

endinterface

// File: rtl/mdu_div_core.sv
// Restoring signed divider datapath (built only with MDU_DIV_EN): one quotient bit per step,
// results exposed combinationally from the step in flight so the final step can be registered directly.
module mdu_div_core
   import mdu_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [MDU_W-1:0] a,
   input  logic [MDU_W-1:0] b,
   output logic [MDU_W-1:0] quo_res,
   output logic [MDU_W-1:0] rem_res
);

   logic [MDU_W-1:0] quo, rem, dvs;
   logic [MDU_W-1:0] quo_nx, rem_nx;
   logic [MDU_W:0]   shifted, trial;
   logic             q_neg, r_neg;

   // Dividend magnitude shifts out of quo's MSB into rem while quotient bits shift in.
   always_comb begin
      shifted = {rem, quo[MDU_W-1]};
      trial   = shifted - {1'b0, dvs};
      if (!trial[MDU_W]) begin
         rem_nx = trial[MDU_W-1:0];
         quo_nx = {quo[MDU_W-2:0], 1'b1};
      end else begin
         rem_nx = shifted[MDU_W-1:0];
         quo_nx = {quo[MDU_W-2:0], 1'b0};
      end
      quo_res = q_neg ? -quo_nx : quo_nx;
      rem_res = r_neg ? -rem_nx : rem_nx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         quo   <= '0;
         rem   <= '0;
         dvs   <= '0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end else if (load) begin
         quo   <= mdu_abs(a);
         rem   <= '0;
         dvs   <= mdu_abs(b);
         q_neg <= a[MDU_W-1] ^ b[MDU_W-1];
         r_neg <= a[MDU_W-1];
      end else if (step) begin
         quo   <= quo_nx;
         rem   <= rem_nx;
      end
   end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed mult (radix-2 Booth) / div unit: done pulses ITER+1 cycles after accept, starts ignored while busy.
// Divider compiled only with MDU_DIV_EN; otherwise div_start completes immediately with hi/lo unchanged.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int ITER = MDU_ITER
)
(
   input logic             clk,
   input logic             reset,
   mult_div_unit_if.slave  bus
);

   mdu_state_e           state, state_nx;
   logic [MDU_CNT_W-1:0] cnt;
   logic                 last;
   logic                 accept_mult, accept_div, accept, div0_set;
   logic [MDU_W:0]       acc, acc_sum;
   logic [MDU_W-1:0]     mplr, mcand;
   logic                 q1;
   logic [MDU_W-1:0]     hi_q, lo_q;
   logic                 div0_q;

   assign last        = (cnt == MDU_CNT_W'(ITER - 1));
   assign accept_mult = (state == IDLE) && bus.mult_start;
   assign accept_div  = (state == IDLE) && bus.div_start && !bus.mult_start;
   assign accept      = accept_mult || accept_div;

`ifdef MDU_DIV_EN
   logic             div_zero;
   logic [MDU_W-1:0] quo_res, rem_res;

   assign div_zero = (bus.b == '0);
   assign div0_set = accept_div && div_zero;

   mdu_div_core u_div (
      .clk     (clk),
      .reset   (reset),
      .load    (accept_div && !div_zero),
      .step    (state == DIV),
      .a       (bus.a),
      .b       (bus.b),
      .quo_res (quo_res),
      .rem_res (rem_res)
   );
`else
   assign div0_set = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept_mult) state_nx = MULT;
`ifdef MDU_DIV_EN
            else if (accept_div) state_nx = div_zero ? FIN : DIV;
`else
            else if (accept_div) state_nx = FIN;
`endif
         end
         MULT:    if (last) state_nx = FIN;
         DIV:     if (last) state_nx = FIN;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Booth recoding on {multiplier LSB, q-1}; acc is one bit wider so -(-2^31) cannot overflow.
   always_comb begin
      acc_sum = acc;
      case ({mplr[0], q1})
         2'b01:   acc_sum = acc + {mcand[MDU_W-1], mcand};
         2'b10:   acc_sum = acc - {mcand[MDU_W-1], mcand};
         default: acc_sum = acc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         acc    <= '0;
         mplr   <= '0;
         mcand  <= '0;
         q1     <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         div0_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt    <= '0;
                  acc    <= '0;
                  mcand  <= bus.a;
                  mplr   <= bus.b;
                  q1     <= 1'b0;
                  div0_q <= div0_set;
               end
            end
            MULT: begin
               cnt  <= cnt + MDU_CNT_W'(1);
               acc  <= {acc_sum[MDU_W], acc_sum[MDU_W:1]};
               mplr <= {acc_sum[0], mplr[MDU_W-1:1]};
               q1   <= mplr[0];
               if (last) begin
                  hi_q <= acc_sum[MDU_W:1];
                  lo_q <= {acc_sum[0], mplr[MDU_W-1:1]};
               end
            end
            DIV: begin
               cnt <= cnt + MDU_CNT_W'(1);
`ifdef MDU_DIV_EN
               if (last) begin
                  hi_q <= rem_res;
                  lo_q <= quo_res;
               end
`endif
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = (state == FIN);
   assign bus.div0 = (state == FIN) && div0_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; divide expectations follow whether MDU_DIV_EN is defined.
module tb_mult_div_unit;

   logic clk = 1'b0;
   logic reset;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   lat, ndone;

   mult_div_unit_if bus ();

   mult_div_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Pulses a start, then leaves the caller in the done cycle; lat = edges after accept (-1 on timeout).
   task automatic run_op(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv,
                         output int l);
      @(posedge clk); #1;
      bus.mult_start = m; bus.div_start = d; bus.a = av; bus.b = bv;
      @(posedge clk); #1;
      bus.mult_start = 1'b0; bus.div_start = 1'b0; bus.a = $urandom; bus.b = $urandom;
      chk("busy_after_accept", bus.busy, 1'b1);
      l = -1;
      for (int i = 0; i < 40; i++) begin
         if (bus.done) begin
            l = i;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic after_done(input string tag);
      @(posedge clk); #1;
      chk({tag, "_done_low"}, bus.done, 1'b0);
      chk({tag, "_busy_low"}, bus.busy, 1'b0);
      chk({tag, "_div0_low"}, bus.div0, 1'b0);
   endtask

   // Runs an op for 45 cycles, pulsing the other start 5 cycles in; counts done pulses.
   task automatic run_intrude(input logic m, input logic [31:0] av, input logic [31:0] bv,
                              output int l, output int nd);
      @(posedge clk); #1;
      bus.mult_start = m; bus.div_start = !m; bus.a = av; bus.b = bv;
      @(posedge clk); #1;
      bus.mult_start = 1'b0; bus.div_start = 1'b0;
      l = -1; nd = 0;
      for (int i = 0; i < 45; i++) begin
         if (bus.done) begin
            nd++;
            if (l < 0) l = i;
         end
         bus.mult_start = (i == 5) && !m;
         bus.div_start  = (i == 5) && m;
         bus.a = $urandom; bus.b = $urandom;
         @(posedge clk); #1;
      end
      bus.mult_start = 1'b0; bus.div_start = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus.mult_start = 1'b0; bus.div_start = 1'b0; bus.a = '0; bus.b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_div0", bus.div0, 1'b0);
      chk("rst_hi", bus.hi, 32'h0);
      chk("rst_lo", bus.lo, 32'h0);
      reset = 1'b0;

      run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, lat);
      chk("m7x-3_lat", lat, 32'd32);
      chk("m7x-3_hi", bus.hi, 32'hFFFF_FFFF);
      chk("m7x-3_lo", bus.lo, 32'hFFFF_FFEB);
      chk("m7x-3_div0", bus.div0, 1'b0);
      after_done("m7x-3");

      run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, lat);
      chk("mmin_lat", lat, 32'd32);
      chk("mmin_hi", bus.hi, 32'h4000_0000);
      chk("mmin_lo", bus.lo, 32'h0000_0000);
      after_done("mmin");

`ifdef MDU_DIV_EN
      run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, lat);
      chk("d-7/2_lat", lat, 32'd32);
      chk("d-7/2_lo", bus.lo, 32'hFFFF_FFFD);
      chk("d-7/2_hi", bus.hi, 32'hFFFF_FFFF);
      after_done("d-7/2");

      run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
      chk("dwrap_lat", lat, 32'd32);
      chk("dwrap_lo", bus.lo, 32'h8000_0000);
      chk("dwrap_hi", bus.hi, 32'h0);
      after_done("dwrap");

      run_op(1'b0, 1'b1, 32'd5, 32'd0, lat);
      chk("d5/0_lat", lat, 32'd0);
      chk("d5/0_div0", bus.div0, 1'b1);
      chk("d5/0_hi", bus.hi, 32'h0);
      chk("d5/0_lo", bus.lo, 32'h8000_0000);
      after_done("d5/0");

      run_intrude(1'b0, 32'hFFFF_FF9C, 32'd7, lat, ndone);
      chk("dint_lat", lat, 32'd32);
      chk("dint_ndone", ndone, 32'd1);
      chk("dint_lo", bus.lo, 32'hFFFF_FFF2);
      chk("dint_hi", bus.hi, 32'hFFFF_FFFE);
`else
      run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, lat);
      chk("dnone_lat", lat, 32'd0);
      chk("dnone_div0", bus.div0, 1'b0);
      chk("dnone_hi", bus.hi, 32'h4000_0000);
      chk("dnone_lo", bus.lo, 32'h0);
      after_done("dnone");

      run_op(1'b0, 1'b1, 32'd5, 32'd0, lat);
      chk("dnone0_lat", lat, 32'd0);
      chk("dnone0_div0", bus.div0, 1'b0);
      chk("dnone0_hi", bus.hi, 32'h4000_0000);
      after_done("dnone0");
`endif

      run_intrude(1'b1, 32'hFFFF_FF9C, 32'd7, lat, ndone);
      chk("mint_lat", lat, 32'd32);
      chk("mint_ndone", ndone, 32'd1);
      chk("mint_hi", bus.hi, 32'hFFFF_FFFF);
      chk("mint_lo", bus.lo, 32'hFFFF_FD44);

      run_op(1'b1, 1'b1, 32'd3, 32'd0, lat);
      chk("both_lat", lat, 32'd32);
      chk("both_div0", bus.div0, 1'b0);
      chk("both_hi", bus.hi, 32'h0);
      chk("both_lo", bus.lo, 32'h0);
      after_done("both");

      run_op(1'b1, 1'b0, 32'hFFFF_FF9C, 32'd7, lat);
      chk("pre_rst_lo", bus.lo, 32'hFFFF_FD44);
      after_done("pre_rst");

      // Abort a multiply at iteration edge E10 with a start also high.
      @(posedge clk); #1;
      bus.mult_start = 1'b1; bus.a = 32'h1234; bus.b = 32'h5678;
      @(posedge clk); #1;
      bus.mult_start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1; bus.mult_start = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", bus.busy, 1'b0);
      chk("abort_done", bus.done, 1'b0);
      chk("abort_div0", bus.div0, 1'b0);
      chk("abort_hi", bus.hi, 32'h0);
      chk("abort_lo", bus.lo, 32'h0);
      reset = 1'b0; bus.mult_start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done || bus.busy) ndone++;
         @(posedge clk); #1;
      end
      chk("abort_no_activity", ndone, 32'd0);

      run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, lat);
      chk("post_rst_lat", lat, 32'd32);
      chk("post_rst_hi", bus.hi, 32'h1);
      chk("post_rst_lo", bus.lo, 32'h0);
      after_done("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
